freq_meter: RTL and testbench

Gated frequency counter that measures an asynchronous square wave against the 100 MHz board clock. It is the measuring end of the team's clock-divider blocks: it counts rising edges of `sigIn` over a fixed gate window and reports edges per window. With the default 1 s gate at 100 MHz, the reading is in Hz. It is used on the Spartan-7 board to verify divider outputs and external signals, and to feed display logic.

---
 rtl/freq_meter_pkg.sv | 18 +
 rtl/sync_edge_det.sv | 37 +++
 rtl/freq_meter.sv | 102 ++++++++++
 tb/tb_freq_meter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency meter and the clock-divider blocks.
// Holds the FSM encoding, the board clock rate and the default gate/counter sizes.
package freq_meter_pkg;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_MEASURE = 1'b1;

    typedef enum logic {
        IDLE    = ST_IDLE,
        MEASURE = ST_MEASURE
    } state_t;

    localparam int CLK_HZ          = 100_000_000;
    localparam int DEF_GATE_CYCLES = CLK_HZ;
    localparam int DEF_CNT_W       = 27;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an async input and flags its rising edges; pulse appears SYNC_STAGES cycles
// after the input rises (no backpressure), and stays inhibited for SYNC_STAGES+1 cycles after reset.
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic inClk,
    input  logic rstN,
    input  logic asyncIn,
    output logic risePulse
);

    localparam int INH_W = $clog2(SYNC_STAGES + 2);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [INH_W-1:0]       inh_cnt;

    always_ff @(posedge inClk) begin
        if (!rstN) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            inh_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], asyncIn};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (inh_cnt != INH_LAST)
                inh_cnt <= inh_cnt + 1'b1;
        end
    end

    // A level already high at reset release looks like an edge while the chain fills; mask it.
    assign risePulse = sync_q[SYNC_STAGES-1] & ~prev_q & (inh_cnt == INH_LAST);

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sigIn rising edges over GATE_CYCLES clocks; result with a
// valid pulse one cycle after the window closes. No backpressure; start is ignored while busy.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             inClk,
    input  logic             rstN,
    input  logic             sigIn,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] freqOut,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_flag;
    logic              rise;
    logic [CNT_W-1:0]  edge_nxt;
    logic              ovf_nxt;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .inClk    (inClk),
        .rstN     (rstN),
        .asyncIn  (sigIn),
        .risePulse(rise)
    );

    // Count including this cycle's edge, so the closing cycle can report it directly.
    always_comb begin
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf_flag;
        if (rise) begin
            if (edge_cnt == CNT_MAX)
                ovf_nxt = 1'b1;
            else
                edge_nxt = edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge inClk) begin
        if (!rstN) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            freqOut  <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                        state    <= MEASURE;
                        busy     <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (gate_cnt == GATE_LAST) begin
                        freqOut  <= edge_nxt;
                        overflow <= ovf_nxt;
                        valid    <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                        if (!continuous) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        edge_cnt <= edge_nxt;
                        ovf_flag <= ovf_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: two instances (wide and 6-bit counters) share one stimulus;
// expected readings come from counting recorded sigIn rising edges inside each window.
module tb_freq_meter;

    localparam int G      = 1000;
    localparam int S      = 2;
    localparam int W_A    = 27;
    localparam int W_B    = 6;
    localparam longint MAX_A = (64'd1 << W_A) - 1;
    localparam longint MAX_B = (64'd1 << W_B) - 1;

    typedef struct {
        int     cyc;
        longint cnt;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic sig = 1'b0;
    logic start = 1'b0;
    logic continuous = 1'b0;

    logic [W_A-1:0] freq_a;
    logic [W_B-1:0] freq_b;
    logic valid_a, valid_b, busy_a, busy_b, ovf_a, ovf_b;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int rises[$];
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t e_mon;

    // waveform generator state
    int hi_len = 1, lo_len = 1, ph = 0;
    bit rnd_per = 0, hold_mode = 0, hold_lvl = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W_A), .SYNC_STAGES(S)) dut_a (
        .inClk(clk), .rstN(rstN), .sigIn(sig), .start(start), .continuous(continuous),
        .freqOut(freq_a), .valid(valid_a), .busy(busy_a), .overflow(ovf_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W_B), .SYNC_STAGES(S)) dut_b (
        .inClk(clk), .rstN(rstN), .sigIn(sig), .start(start), .continuous(continuous),
        .freqOut(freq_b), .valid(valid_b), .busy(busy_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic gen(output logic l);
        if (hold_mode) begin
            l = hold_lvl;
        end else begin
            l = (ph >= lo_len);
            ph++;
            if (ph >= lo_len + hi_len) begin
                ph = 0;
                if (rnd_per) begin
                    lo_len = $urandom_range(2, 9);
                    hi_len = $urandom_range(2, 9);
                end
            end
        end
    endtask

    task automatic set_period(input int hi, input int lo);
        hi_len = hi; lo_len = lo; ph = 0; rnd_per = 0; hold_mode = 0;
    endtask

    // One clock: inputs change 1 time unit after the edge; cyc is the index of this cycle.
    task automatic drive_cycle(input logic st, input logic cont, input logic rn);
        logic l;
        @(posedge clk);
        #1;
        gen(l);
        if (l && !sig) rises.push_back(cyc);
        sig = l;
        start = st;
        continuous = cont;
        rstN = rn;
    endtask

    function automatic logic noise();
        return ($urandom_range(0, 63) == 0);
    endfunction

    // Window occupies cycles w..w+G-1; an edge driven in cycle r is seen in cycle r+S.
    task automatic push_expect(input int w);
        longint n;
        exp_t e;
        n = 0;
        foreach (rises[i])
            if (rises[i] + S >= w && rises[i] + S <= w + G - 1) n++;
        e.cyc = w + G;
        e.cnt = (n > MAX_A) ? MAX_A : n;
        e.ovf = (n > MAX_A);
        exp_a.push_back(e);
        e.cnt = (n > MAX_B) ? MAX_B : n;
        e.ovf = (n > MAX_B);
        exp_b.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_freq_a"}, freq_a, 0);
        check({tag, "_freq_b"}, freq_b, 0);
        check({tag, "_valid_a"}, valid_a, 0);
        check({tag, "_valid_b"}, valid_b, 0);
        check({tag, "_busy_a"}, busy_a, 0);
        check({tag, "_busy_b"}, busy_b, 0);
        check({tag, "_ovf_a"}, ovf_a, 0);
        check({tag, "_ovf_b"}, ovf_b, 0);
    endtask

    task automatic reset_seq(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            if (i > 0) check_zero("reset");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic window_single();
        int w;
        drive_cycle(1'b1, 1'b0, 1'b1);
        w = cyc + 1;
        for (int i = 0; i < G; i++) begin
            drive_cycle(noise(), 1'b0, 1'b1);
            if (i == 0) begin
                check("busy_after_start_a", busy_a, 1);
                check("busy_after_start_b", busy_b, 1);
            end
        end
        push_expect(w);
        drive_cycle(1'b0, 1'b0, 1'b1);
        check("busy_after_single_a", busy_a, 0);
    endtask

    task automatic window_cont(input int nwin, input int drop);
        int w;
        logic c;
        drive_cycle(1'b0, 1'b1, 1'b1);
        w = cyc + 1;
        for (int k = 0; k < nwin; k++) begin
            for (int i = 0; i < G; i++) begin
                c = !(k == nwin - 1 && i >= drop);
                drive_cycle(noise(), c, 1'b1);
                if (i == 0) check("busy_cont_a", busy_a, 1);
            end
            push_expect(w + k * G);
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
        check("busy_after_cont_a", busy_a, 0);
        check("busy_after_cont_b", busy_b, 0);
    endtask

    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_valid_a at cycle %0d: freqOut=%0d, no window outstanding", cyc, freq_a);
            end else begin
                e_mon = exp_a.pop_front();
                check("valid_cycle_a", cyc, e_mon.cyc);
                check("freq_a", freq_a, e_mon.cnt);
                check("ovf_a", ovf_a, e_mon.ovf);
            end
        end
        if (valid_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_valid_b at cycle %0d: freqOut=%0d, no window outstanding", cyc, freq_b);
            end else begin
                e_mon = exp_b.pop_front();
                check("valid_cycle_b", cyc, e_mon.cyc);
                check("freq_b", freq_b, e_mon.cnt);
                check("ovf_b", ovf_b, e_mon.ovf);
            end
        end
    end

    initial begin
        // reset with sigIn toggling
        set_period(1, 1);
        reset_seq(5);
        idle(8);
        check_zero("post_reset");

        // single window, period 10
        set_period(5, 5);
        window_single();

        // continuous, period 4, continuous dropped mid third window
        set_period(2, 2);
        window_cont(3, 500);

        // slow signal after a saturated window
        set_period(50, 50);
        window_single();

        // sigIn high across reset release, held high
        hold_mode = 1; hold_lvl = 1;
        reset_seq(5);
        idle(8);
        window_single();

        // reset in the middle of a window, then max-rate signal
        set_period(3, 4);
        drive_cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 500; i++) drive_cycle(noise(), 1'b0, 1'b1);
        reset_seq(3);
        idle(8);
        check_zero("after_abandon");
        set_period(1, 1);
        window_single();

        // randomized periods and modes
        set_period(3, 3);
        rnd_per = 1;
        for (int k = 0; k < 5; k++) begin
            idle($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 0)
                window_single();
            else
                window_cont(2, $urandom_range(1, G - 1));
        end

        idle(10);
        check("pending_a", exp_a.size(), 0);
        check("pending_b", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
